// File: rtl/mul_mac_sequencer.sv
// Multiply-accumulate front end: queues CPU operand pairs, drives the sequential
// multiplier over its register bus and sums 64-bit products into an accumulator.
module mul_mac_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   input  logic        we,
   input  logic        re,
   output logic [7:0]  m_address,
   output logic [31:0] m_write_data,
   input  logic [31:0] m_read_data,
   output logic        m_we,
   output logic        m_re
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_READ_H, S_READ_L
   } state_t;

   state_t        state_q, state_d;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   opa_q, opa_d, a_q, a_d, b_q, b_d, hi_q, hi_d;
   logic [63:0]   acc_q, acc_d;
   logic [31:0]   count_q, count_d;
   logic          overflow_q, overflow_d;

   logic full, busy, pop, push_req, push;
   logic unused_re;

   // Reads have no side effects, so the read strobe carries no information here.
   assign unused_re = re;

   assign full     = (cnt_q == FULL_CNT);
   assign busy     = (state_q != S_IDLE) || (cnt_q != '0);
   assign pop      = (state_q == S_IDLE) && (cnt_q != '0);
   assign push_req = we && (address == 8'h08);
   assign push     = push_req && (!full || pop);

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      opa_d      = opa_q;
      a_d        = a_q;
      b_d        = b_q;
      hi_d       = hi_q;
      acc_d      = acc_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (we && (address == 8'h04)) opa_d = write_data;
      if (push) begin
         mem_d[wr_ptr_q] = {opa_q, write_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (push_req && !push) overflow_d = 1'b1;
      if (pop) begin
         a_d      = mem_q[rd_ptr_q][63:32];
         b_d      = mem_q[rd_ptr_q][31:0];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case (state_q)
         S_IDLE:   if (pop) state_d = S_LOAD_A;
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: state_d = S_WAIT;
         S_WAIT:   if (!m_read_data[0]) state_d = S_READ_H;
         S_READ_H: begin
            hi_d    = m_read_data;
            state_d = S_READ_L;
         end
         S_READ_L: begin
            acc_d   = acc_q + {hi_q, m_read_data};
            count_d = count_q + 32'd1;
            state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase

      // A software clear overrides a MAC completing in the same cycle.
      if (we && (address == 8'h14)) begin
         if (write_data[0]) begin
            acc_d   = '0;
            count_d = '0;
         end
         if (write_data[1]) overflow_d = 1'b0;
      end
   end

   always_comb begin
      m_we         = 1'b0;
      m_re         = 1'b0;
      m_address    = 8'h00;
      m_write_data = 32'h0;
      case (state_q)
         S_LOAD_A: begin
            m_we         = 1'b1;
            m_address    = 8'h04;
            m_write_data = a_q;
         end
         S_LOAD_B: begin
            m_we         = 1'b1;
            m_address    = 8'h08;
            m_write_data = b_q;
         end
         S_WAIT: begin
            m_re      = 1'b1;
            m_address = 8'h00;
         end
         S_READ_H: begin
            m_re      = 1'b1;
            m_address = 8'h0C;
         end
         S_READ_L: begin
            m_re      = 1'b1;
            m_address = 8'h10;
         end
         default: ;
      endcase
   end

   always_comb begin
      read_data = 32'h0;
      case (address)
         8'h00: read_data = {24'h0, 4'(cnt_q), 1'b0, overflow_q, full, busy};
         8'h04: read_data = opa_q;
         8'h0C: read_data = acc_q[63:32];
         8'h10: read_data = acc_q[31:0];
         8'h18: read_data = count_q;
         default: read_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         opa_q      <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         opa_q      <= opa_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_mul_mac_sequencer.sv
// Bench for mul_mac_sequencer: behavioural multiplier peripheral, bus monitor with
// an operand-pair scoreboard, and CPU-side register checks against a small model.
module tb_mul_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  address = 8'h00;
   logic [31:0] write_data = 32'h0;
   logic [31:0] read_data;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [7:0]  m_address;
   logic [31:0] m_write_data;
   logic [31:0] m_read_data;
   logic        m_we;
   logic        m_re;

   int n_total = 0;
   int n_bad   = 0;

   logic [63:0] exp_q[$];
   logic [63:0] acc_exp   = 64'h0;
   logic [31:0] count_exp = 32'h0;
   logic [31:0] opa_shadow = 32'h0;

   // multiplier model state
   logic [31:0] mul1 = 32'h0;
   logic [63:0] prod = 64'h0;
   int          busy_cnt = 0;

   // monitor state
   logic [31:0] mon_mul1 = 32'h0;
   int          poll_cnt = 0;
   int          mwe_cnt  = 0;

   mul_mac_sequencer #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .address(address), .write_data(write_data),
      .read_data(read_data), .we(we), .re(re), .m_address(m_address),
      .m_write_data(m_write_data), .m_read_data(m_read_data), .m_we(m_we), .m_re(m_re)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Sequential multiplier: busy for 32 cycles after a MUL2 write.
   always @(posedge clk) begin
      if (m_we && m_address == 8'h04) mul1 <= m_write_data;
      if (m_we && m_address == 8'h08) begin
         prod     <= {32'h0, mul1} * {32'h0, m_write_data};
         busy_cnt <= 32;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   always_comb begin
      case (m_address)
         8'h00:   m_read_data = {31'h0, busy_cnt != 0};
         8'h0C:   m_read_data = prod[63:32];
         8'h10:   m_read_data = prod[31:0];
         default: m_read_data = 32'h0;
      endcase
   end

   always @(negedge clk) begin
      if (m_we) mwe_cnt++;
      if (m_re && m_address == 8'h00) poll_cnt++;
      if (m_we && m_address == 8'h04) mon_mul1 = m_write_data;
      if (m_we && m_address == 8'h08) begin
         if (exp_q.size() == 0) chk("sb_underflow", {mon_mul1, m_write_data}, 64'h0);
         else chk("sb_pair", {mon_mul1, m_write_data}, exp_q.pop_front());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
      address = a;
      write_data = d;
      we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      if (a == 8'h04) opa_shadow = d;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [31:0] d);
      address = a;
      re = 1'b1;
      #1;
      d = read_data;
      re = 1'b0;
   endtask

   task automatic push_b(input logic [31:0] b, input bit accepted);
      cpu_write(8'h08, b);
      if (accepted) begin
         exp_q.push_back({opa_shadow, b});
         acc_exp   = acc_exp + {32'h0, opa_shadow} * {32'h0, b};
         count_exp = count_exp + 32'd1;
      end
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      logic [31:0] st;
      bit done = 1'b0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         cpu_read(8'h00, st);
         if (!st[0]) done = 1'b1;
         else tick(1);
      end
      chk(tag, {63'h0, done}, 64'h1);
   endtask

   task automatic chk_acc(input string tag);
      logic [31:0] hi, lo, cnt;
      cpu_read(8'h0C, hi);
      cpu_read(8'h10, lo);
      cpu_read(8'h18, cnt);
      chk({tag, "_acc"}, {hi, lo}, acc_exp);
      chk({tag, "_count"}, {32'h0, cnt}, {32'h0, count_exp});
   endtask

   initial begin
      logic [31:0] d;
      logic [63:0] pre;
      int polls0, mwe0;

      tick(3);
      rst = 1'b0;
      // reset state
      cpu_read(8'h00, d); chk("rst_status", {32'h0, d}, 64'h0);
      cpu_read(8'h04, d); chk("rst_opa", {32'h0, d}, 64'h0);
      chk_acc("rst");
      chk("rst_mbus", {m_we, m_re, m_address, m_write_data}, 64'h0);

      // 3 x 5 with exact latency and poll count
      cpu_write(8'h04, 32'd3);
      polls0 = poll_cnt;
      push_b(32'd5, 1'b1);
      cpu_read(8'h00, d); chk("t1_status_queued", {32'h0, d}, 64'h11);
      tick(37);
      cpu_read(8'h10, d); chk("t1_acc_before", {32'h0, d}, 64'h0);
      tick(1);
      chk_acc("t1");
      cpu_read(8'h10, d); chk("t1_accl_lit", {32'h0, d}, 64'hF);
      cpu_read(8'h00, d); chk("t1_status_done", {32'h0, d}, 64'h0);
      chk("t1_polls", poll_cnt - polls0, 64'd33);

      // max operands, sum wraps; OPA rewrite must not alter queued entries
      cpu_write(8'h14, 32'h1); acc_exp = 0; count_exp = 0;
      cpu_write(8'h04, 32'hFFFF_FFFF);
      push_b(32'hFFFF_FFFF, 1'b1);
      push_b(32'hFFFF_FFFF, 1'b1);
      cpu_write(8'h04, 32'h55);
      wait_idle("t2_idle", 200);
      chk_acc("t2");
      cpu_read(8'h0C, d); chk("t2_acch_lit", {32'h0, d}, 64'hFFFF_FFFC);
      cpu_read(8'h10, d); chk("t2_accl_lit", {32'h0, d}, 64'h2);
      cpu_read(8'h04, d); chk("t2_opa", {32'h0, d}, 64'h55);

      // overflow with six back-to-back pushes, then a push accepted while full+pop
      cpu_write(8'h14, 32'h1); acc_exp = 0; count_exp = 0;
      cpu_write(8'h04, 32'd1);
      for (int i = 1; i <= 6; i++) push_b(i, i <= 5);
      cpu_read(8'h00, d); chk("t3_status_full", {32'h0, d}, 64'h47);
      tick(33);
      cpu_read(8'h00, d); chk("t3_status_pop", {32'h0, d}, 64'h47);
      push_b(32'd7, 1'b1);
      wait_idle("t3_idle", 300);
      chk_acc("t3");
      cpu_read(8'h00, d); chk("t3_status_ovf", {32'h0, d}, 64'h4);
      cpu_write(8'h14, 32'h2);
      cpu_read(8'h00, d); chk("t3_ovf_clr", {32'h0, d}, 64'h0);
      cpu_read(8'h10, d); chk("t3_acc_kept", {32'h0, d}, {32'h0, acc_exp[31:0]});

      // clear coincident with READ_L wins
      pre = acc_exp;
      cpu_write(8'h04, 32'd2);
      push_b(32'd3, 1'b1);
      tick(37);
      cpu_read(8'h10, d); chk("t4_acc_before", {32'h0, d}, {32'h0, pre[31:0]});
      cpu_write(8'h14, 32'h1);
      acc_exp = 0; count_exp = 0;
      chk_acc("t4_clr");
      cpu_write(8'h04, 32'd4);
      push_b(32'd5, 1'b1);
      wait_idle("t4_idle", 100);
      chk_acc("t4_after");

      // reset mid-WAIT with two entries queued
      cpu_write(8'h04, 32'd1);
      push_b(32'd10, 1'b1);
      push_b(32'd11, 1'b1);
      push_b(32'd12, 1'b1);
      tick(10);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_q.delete();
      acc_exp = 0; count_exp = 0; opa_shadow = 0;
      cpu_read(8'h00, d); chk("t5_status", {32'h0, d}, 64'h0);
      cpu_read(8'h04, d); chk("t5_opa", {32'h0, d}, 64'h0);
      chk_acc("t5_rst");
      mwe0 = mwe_cnt;
      tick(50);
      chk("t5_no_mwe", mwe_cnt, mwe0);
      cpu_write(8'h04, 32'd7);
      push_b(32'd6, 1'b1);
      tick(38);
      chk_acc("t5_new");
      cpu_read(8'h10, d); chk("t5_accl_lit", {32'h0, d}, 64'd42);

      // unmapped offsets
      cpu_read(8'h1C, d); chk("t6_rd_1c", {32'h0, d}, 64'h0);
      cpu_read(8'hFF, d); chk("t6_rd_ff", {32'h0, d}, 64'h0);
      cpu_read(8'h14, d); chk("t6_rd_ctrl", {32'h0, d}, 64'h0);
      mwe0 = mwe_cnt;
      cpu_write(8'h1C, 32'hFFFF_FFFF);
      cpu_write(8'hFF, 32'hFFFF_FFFF);
      tick(2);
      cpu_read(8'h00, d); chk("t6_status", {32'h0, d}, 64'h0);
      cpu_read(8'h04, d); chk("t6_opa", {32'h0, d}, 64'd7);
      chk_acc("t6");
      chk("t6_no_mwe", mwe_cnt, mwe0);

      chk("sb_leftover", exp_q.size(), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
